// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment decoder: segment bit names,
// all-off/all-on patterns and the active-high gfedcba digit table.
package seven_seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [7:0] SEG_ALL = 8'hFF;

  // Entry [n] is the active-high gfedcba pattern for hex digit n
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seven_seg_rom.sv
// Nibble to active-high gfedcba segment lookup.
// Latency: combinational. Backpressure: none.
// All 16 codes are defined, so every input value maps to a pattern.
module seven_seg_rom
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg.sv
// Registered hex digit to seven-segment driver with blank, lamp test and blink (SEVEN_SEG_BLINK_EN).
// Latency: 1 cycle from any input to OUT; RESET forces all-off asynchronously.
// Backpressure: none; OUT follows inputs every cycle.
module seven_seg
  import seven_seg_pkg::*;
#(
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [3:0] IN,
  input  logic       DP,
  input  logic       BLANK,
  input  logic       LAMP_TEST,
  input  logic       BLINK,
  output logic [7:0] OUT
);

  localparam logic [7:0] OFF_LEVEL = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

  logic [6:0] rom_seg;
  logic       blink_off;
  logic [7:0] lit;
  logic [7:0] out_nxt;

  seven_seg_rom u_rom (
    .nibble (IN),
    .seg    (rom_seg)
  );

`ifdef SEVEN_SEG_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  // Free-running regardless of BLINK so every digit blinks in step
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + CNT_W'(1);
    end
  end

  assign blink_off = BLINK & blink_phase;
`else
  localparam int unsigned BLINK_DIV_UNUSED = BLINK_DIV;
  logic blink_unused;

  assign blink_unused = BLINK;
  assign blink_off    = 1'b0;
`endif

  always_comb begin
    lit                = SEG_OFF;
    lit[SEG_G:SEG_A]   = rom_seg;
    lit[SEG_DP]        = DP;
    if (LAMP_TEST) begin
      lit = SEG_ALL;
    end else if (BLANK || blink_off) begin
      lit = SEG_OFF;
    end
    out_nxt = ACTIVE_LOW ? ~lit : lit;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      OUT <= OFF_LEVEL;
    end else begin
      OUT <= out_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg.sv
// Directed bench for seven_seg: one active-low and one active-high instance share stimulus.
module tb_seven_seg;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b0;
  logic [3:0] IN       = 4'h5;
  logic       DP       = 1'b1;
  logic       BLANK    = 1'b0;
  logic       LAMP_TEST = 1'b0;
  logic       BLINK    = 1'b0;
  logic [7:0] out_lo;
  logic [7:0] out_hi;

  int total = 0;
  int bad   = 0;

  // Hand-computed expectations, DP = 0
  logic [7:0] exp_lo [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] exp_hi [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  seven_seg #(.ACTIVE_LOW(1'b1), .BLINK_DIV(4)) u_lo (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .IN        (IN),
    .DP        (DP),
    .BLANK     (BLANK),
    .LAMP_TEST (LAMP_TEST),
    .BLINK     (BLINK),
    .OUT       (out_lo)
  );

  seven_seg #(.ACTIVE_LOW(1'b0), .BLINK_DIV(4)) u_hi (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .IN        (IN),
    .DP        (DP),
    .BLANK     (BLANK),
    .LAMP_TEST (LAMP_TEST),
    .BLINK     (BLINK),
    .OUT       (out_hi)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Asynchronous reset, checked between clock edges
    #1 RESET = 1'b1;
    #1;
    chk("reset_lo", out_lo, 8'hFF);
    chk("reset_hi", out_hi, 8'h00);

    @(negedge CLOCK_50);
    RESET = 1'b0;
    IN = 4'h0;
    DP = 1'b0;
    tick;
    chk("first_lo", out_lo, 8'hC0);
    chk("first_hi", out_hi, 8'h3F);

    for (int i = 0; i < 16; i++) begin
      IN = 4'(i);
      tick;
      chk($sformatf("sweep_lo_%0h", i), out_lo, exp_lo[i]);
      chk($sformatf("sweep_hi_%0h", i), out_hi, exp_hi[i]);
    end

    IN = 4'h8;
    DP = 1'b1;
    tick;
    chk("dp8_lo", out_lo, 8'h00);
    chk("dp8_hi", out_hi, 8'hFF);

    BLANK = 1'b1;
    tick;
    chk("blank_lo", out_lo, 8'hFF);
    chk("blank_hi", out_hi, 8'h00);

    LAMP_TEST = 1'b1;
    tick;
    chk("lamp_lo", out_lo, 8'h00);
    chk("lamp_hi", out_hi, 8'hFF);

    LAMP_TEST = 1'b0;
    BLANK = 1'b0;
    IN = 4'h9;
    tick;
    chk("dp9_lo", out_lo, 8'h10);
    chk("dp9_hi", out_hi, 8'hEF);

    // Reset mid-operation clears OUT without waiting for an edge
    #2 RESET = 1'b1;
    #1;
    chk("midreset_lo", out_lo, 8'hFF);
    chk("midreset_hi", out_hi, 8'h00);

    // Blink: release reset at a falling edge so the counter phase is known
    @(negedge CLOCK_50);
    IN = 4'h1;
    DP = 1'b0;
    BLINK = 1'b1;
    RESET = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      tick;
`ifdef SEVEN_SEG_BLINK_EN
      chk($sformatf("blink_%0d", n), out_lo, (((n - 1) / 4) % 2 == 0) ? 8'hF9 : 8'hFF);
`else
      chk($sformatf("blink_%0d", n), out_lo, 8'hF9);
`endif
    end

    LAMP_TEST = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick;
      chk($sformatf("blink_lamp_%0d", n), out_lo, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
